// File: rtl/fifo_out_merge_if.sv
// Handshake bundle for the two-channel FIFO output merger: two input beat
// channels, one merged output channel and the per-channel beat counters.
interface fifo_out_merge_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] data_in0;
  logic                  data_in0_vld;
  logic                  data_in0_rdy;
  logic [DATA_WIDTH-1:0] data_in1;
  logic                  data_in1_vld;
  logic                  data_in1_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_src;
  logic                  data_out_vld;
  logic                  data_out_rdy;
  logic [CNT_WIDTH-1:0]  cnt0;
  logic [CNT_WIDTH-1:0]  cnt1;

  modport slave (
    input  data_in0, data_in0_vld, data_in1, data_in1_vld, data_out_rdy,
    output data_in0_rdy, data_in1_rdy, data_out, data_out_src, data_out_vld,
    output cnt0, cnt1
  );

  modport master (
    output data_in0, data_in0_vld, data_in1, data_in1_vld, data_out_rdy,
    input  data_in0_rdy, data_in1_rdy, data_out, data_out_src, data_out_vld,
    input  cnt0, cnt1
  );
endinterface

// File: rtl/fifo_out_merge.sv
// Round-robin merge of two FIFO output channels into a 2-entry in-order
// output buffer of {src, data}, with saturating per-channel beat counters.
module fifo_out_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  fifo_out_merge_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  occ_t                  occ_r;
  occ_t                  occ_s;
  logic                  last_r;
  logic                  grant_s;
  logic                  can_accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] in_data_s;
  logic [DATA_WIDTH-1:0] head_data_r;
  logic                  head_src_r;
  logic [DATA_WIDTH-1:0] tail_data_r;
  logic                  tail_src_r;
  logic [CNT_WIDTH-1:0]  cnt0_r;
  logic [CNT_WIDTH-1:0]  cnt1_r;

  // Grant and acceptance use only registered state and the vld inputs, so
  // there is no combinational path from data_out_rdy to either input rdy.
  always_comb begin
    grant_s      = 1'b0;
    can_accept_s = 1'b0;
    in_data_s    = {DATA_WIDTH{1'b0}};
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (bus.data_in0_vld && bus.data_in1_vld) begin
      grant_s = ~last_r;
    end else if (bus.data_in1_vld) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    can_accept_s = ~rst & (occ_r != FULL) & (bus.data_in0_vld | bus.data_in1_vld);
    if (grant_s) begin
      in_data_s = bus.data_in1;
    end else begin
      in_data_s = bus.data_in0;
    end
    push_s = can_accept_s;
    pop_s  = (occ_r != EMPTY) & bus.data_out_rdy;
  end

  // Occupancy next-state.
  always_comb begin
    occ_s = occ_r;
    case (occ_r)
      EMPTY:   occ_s = push_s ? ONE : EMPTY;
      ONE: begin
        if (push_s && !pop_s) begin
          occ_s = FULL;
        end else if (!push_s && pop_s) begin
          occ_s = EMPTY;
        end else begin
          occ_s = ONE;
        end
      end
      FULL:    occ_s = pop_s ? ONE : FULL;
      default: occ_s = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= EMPTY;
    end else begin
      occ_r <= occ_s;
    end
  end

  // Buffer storage: head is the visible beat, tail only fills at FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_r <= {DATA_WIDTH{1'b0}};
      head_src_r  <= 1'b0;
      tail_data_r <= {DATA_WIDTH{1'b0}};
      tail_src_r  <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == EMPTY) begin
            head_data_r <= in_data_s;
            head_src_r  <= grant_s;
          end else begin
            tail_data_r <= in_data_s;
            tail_src_r  <= grant_s;
          end
        end
        2'b01: begin
          head_data_r <= tail_data_r;
          head_src_r  <= tail_src_r;
        end
        2'b11: begin
          head_data_r <= in_data_s;
          head_src_r  <= grant_s;
        end
        default: begin
          head_data_r <= head_data_r;
          head_src_r  <= head_src_r;
        end
      endcase
    end
  end

  // Last-grant register and saturating per-channel transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
      cnt0_r <= {CNT_WIDTH{1'b0}};
      cnt1_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        last_r <= grant_s;
      end
      if (push_s && !grant_s && (cnt0_r != CNT_MAX)) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end
      if (push_s && grant_s && (cnt1_r != CNT_MAX)) begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end
    end
  end

  assign bus.data_in0_rdy = can_accept_s & ~grant_s;
  assign bus.data_in1_rdy = can_accept_s & grant_s;
  assign bus.data_out     = head_data_r;
  assign bus.data_out_src = head_src_r;
  assign bus.data_out_vld = (occ_r != EMPTY);
  assign bus.cnt0         = cnt0_r;
  assign bus.cnt1         = cnt1_r;

endmodule

// File: tb/tb_fifo_out_merge.sv
// Bench for fifo_out_merge: directed vector table, counter saturation on a
// narrow-counter instance, and random stall traffic against a queue model.
module tb_fifo_out_merge;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  fifo_out_merge_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
  fifo_out_merge_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

  fifo_out_merge #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  fifo_out_merge #(.DATA_WIDTH(8), .CNT_WIDTH(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, v0, v1;
    logic [7:0] d0, d1;
    logic       ordy;
    logic       er0, er1, evld, chkd;
    logic [7:0] edata;
    logic       esrc;
    logic [15:0] ec0, ec1;
  } vec_t;

  vec_t tbl[24];

  typedef struct {
    logic       src;
    logic [7:0] data;
  } beat_t;

  // reference model state
  beat_t      mq[$];
  bit         m_last;
  int         m_c0, m_c1;
  // DUT-observed scoreboard
  logic [7:0] sent0[$];
  logic [7:0] sent1[$];
  int         n0, n1, beats;
  bit         h0, h1;
  logic       v0r, v1r, ordy_r;
  logic [7:0] d0r, d1r;

  task automatic drive(input logic r, input logic v0, input logic v1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic ordy);
    rst              = r;
    bus.data_in0_vld = v0;
    bus.data_in1_vld = v1;
    bus.data_in0     = d0;
    bus.data_in1     = d1;
    bus.data_out_rdy = ordy;
  endtask

  task automatic rand_cycle(input bit active);
    bit   g, acc;
    beat_t b;
    @(posedge clk);
    #1;
    if (!h0) begin
      v0r = active && ($urandom_range(0, 99) < 65);
      d0r = 8'($urandom);
    end
    if (!h1) begin
      v1r = active && ($urandom_range(0, 99) < 65);
      d1r = 8'($urandom);
    end
    ordy_r = active ? ($urandom_range(0, 99) < 70) : 1'b1;
    drive(1'b0, v0r, v1r, d0r, d1r, ordy_r);
    #3;
    g   = (v0r && v1r) ? !m_last : v1r;
    acc = (mq.size() < 2) && (v0r || v1r);
    chk("rnd rdy0", bus.data_in0_rdy, acc && !g);
    chk("rnd rdy1", bus.data_in1_rdy, acc && g);
    chk("rnd out_vld", bus.data_out_vld, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("rnd out_data", bus.data_out, mq[0].data);
      chk("rnd out_src", bus.data_out_src, mq[0].src);
    end
    chk("rnd cnt0", bus.cnt0, m_c0);
    chk("rnd cnt1", bus.cnt1, m_c1);
    // per-channel order scoreboard driven by observed handshakes
    if (bus.data_in0_vld && bus.data_in0_rdy) begin sent0.push_back(d0r); n0++; end
    if (bus.data_in1_vld && bus.data_in1_rdy) begin sent1.push_back(d1r); n1++; end
    if (bus.data_out_vld && ordy_r) begin
      beats++;
      if (bus.data_out_src) begin
        if (sent1.size() == 0) chk("sb ch1 spurious beat", 32'd1, 32'd0);
        else chk("sb ch1 order", bus.data_out, sent1.pop_front());
      end else begin
        if (sent0.size() == 0) chk("sb ch0 spurious beat", 32'd1, 32'd0);
        else chk("sb ch0 order", bus.data_out, sent0.pop_front());
      end
    end
    h0 = v0r && !bus.data_in0_rdy;
    h1 = v1r && !bus.data_in1_rdy;
    if ((mq.size() != 0) && ordy_r) void'(mq.pop_front());
    if (acc) begin
      b.src  = g;
      b.data = g ? d1r : d0r;
      mq.push_back(b);
      m_last = g;
      if (g) m_c1++; else m_c0++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst4 = 1'b1;
    bus4.data_in0 = 8'h00; bus4.data_in0_vld = 1'b0;
    bus4.data_in1 = 8'h00; bus4.data_in1_vld = 1'b0;
    bus4.data_out_rdy = 1'b0;

    tbl[0]  = '{0,1,1,8'h11,8'h22,1, 1,0,0,1,8'h00,0,16'd0,16'd0};
    tbl[1]  = '{0,1,1,8'h11,8'h22,1, 0,1,1,1,8'h11,0,16'd1,16'd0};
    tbl[2]  = '{0,1,1,8'h11,8'h22,1, 1,0,1,1,8'h22,1,16'd1,16'd1};
    tbl[3]  = '{0,1,1,8'h11,8'h22,1, 0,1,1,1,8'h11,0,16'd2,16'd1};
    tbl[4]  = '{0,0,0,8'h00,8'h00,1, 0,0,1,1,8'h22,1,16'd2,16'd2};
    tbl[5]  = '{0,1,1,8'h33,8'h44,0, 1,0,0,0,8'h00,0,16'd2,16'd2};
    tbl[6]  = '{0,1,1,8'h33,8'h44,0, 0,1,1,1,8'h33,0,16'd3,16'd2};
    tbl[7]  = '{0,1,1,8'h33,8'h44,0, 0,0,1,1,8'h33,0,16'd3,16'd3};
    tbl[8]  = '{0,1,1,8'h33,8'h44,1, 0,0,1,1,8'h33,0,16'd3,16'd3};
    tbl[9]  = '{0,1,1,8'h33,8'h44,1, 1,0,1,1,8'h44,1,16'd3,16'd3};
    tbl[10] = '{0,0,0,8'h00,8'h00,1, 0,0,1,1,8'h33,0,16'd4,16'd3};
    tbl[11] = '{0,0,1,8'h00,8'hA0,1, 0,1,0,0,8'h00,0,16'd4,16'd3};
    tbl[12] = '{0,0,1,8'h00,8'hA1,1, 0,1,1,1,8'hA0,1,16'd4,16'd4};
    tbl[13] = '{0,0,1,8'h00,8'hA2,1, 0,1,1,1,8'hA1,1,16'd4,16'd5};
    tbl[14] = '{0,0,1,8'h00,8'hA3,1, 0,1,1,1,8'hA2,1,16'd4,16'd6};
    tbl[15] = '{0,0,0,8'h00,8'h00,1, 0,0,1,1,8'hA3,1,16'd4,16'd7};
    tbl[16] = '{0,1,0,8'h50,8'h00,1, 1,0,0,0,8'h00,0,16'd4,16'd7};
    tbl[17] = '{0,0,0,8'h00,8'h00,1, 0,0,1,1,8'h50,0,16'd5,16'd7};
    tbl[18] = '{0,1,1,8'h55,8'h66,0, 0,1,0,0,8'h00,0,16'd5,16'd7};
    tbl[19] = '{0,1,1,8'h55,8'h66,0, 1,0,1,1,8'h66,1,16'd5,16'd8};
    tbl[20] = '{1,1,1,8'h55,8'h66,0, 0,0,1,1,8'h66,1,16'd6,16'd8};
    tbl[21] = '{0,1,1,8'h55,8'h66,0, 1,0,0,1,8'h00,0,16'd0,16'd0};
    tbl[22] = '{0,0,0,8'h00,8'h00,1, 0,0,1,1,8'h55,0,16'd1,16'd0};
    tbl[23] = '{0,0,0,8'h00,8'h00,1, 0,0,0,0,8'h00,0,16'd1,16'd0};

    // reset with both channels requesting: rdy must stay low
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
      #3;
      chk($sformatf("reset%0d rdy0", k), bus.data_in0_rdy, 1'b0);
      chk($sformatf("reset%0d rdy1", k), bus.data_in1_rdy, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].ordy);
      #3;
      chk($sformatf("row%0d rdy0", i), bus.data_in0_rdy, tbl[i].er0);
      chk($sformatf("row%0d rdy1", i), bus.data_in1_rdy, tbl[i].er1);
      chk($sformatf("row%0d out_vld", i), bus.data_out_vld, tbl[i].evld);
      if (tbl[i].chkd) begin
        chk($sformatf("row%0d out_data", i), bus.data_out, tbl[i].edata);
        chk($sformatf("row%0d out_src", i), bus.data_out_src, tbl[i].esrc);
      end
      chk($sformatf("row%0d cnt0", i), bus.cnt0, tbl[i].ec0);
      chk($sformatf("row%0d cnt1", i), bus.cnt1, tbl[i].ec1);
    end

    // 4-bit counter: 20 channel-0 beats, count must stop at 15
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      rst4 = 1'b0;
      bus4.data_in0_vld = (i < 20);
      bus4.data_in0     = 8'(i);
      bus4.data_out_rdy = 1'b1;
      #3;
      chk($sformatf("sat%0d rdy0", i), bus4.data_in0_rdy, (i < 20));
      chk($sformatf("sat%0d cnt0", i), bus4.cnt0, (i < 15) ? i : 15);
      chk($sformatf("sat%0d cnt1", i), bus4.cnt1, 0);
    end

    // random stall traffic
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    mq.delete();
    m_last = 1'b1;
    m_c0 = 0; m_c1 = 0; n0 = 0; n1 = 0; beats = 0;
    h0 = 1'b0; h1 = 1'b0;
    cyc = 0;
    while ((beats < 10000) && (cyc < 50000)) begin
      rand_cycle(1'b1);
      cyc++;
    end
    chk("random beat budget", (beats >= 10000), 1'b1);
    h0 = 1'b0; h1 = 1'b0;
    for (int k = 0; k < 4; k++) rand_cycle(1'b0);
    chk("drain ch0 leftovers", sent0.size(), 0);
    chk("drain ch1 leftovers", sent1.size(), 0);
    chk("total cnt0", bus.cnt0, n0);
    chk("total cnt1", bus.cnt1, n1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_out_merge.md
FIFO_OUT_MERGE -- requirements
Module: fifo_out_merge

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each data beat.
REQ-002 Parameter CNT_WIDTH, default 16, width of each per-channel beat counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 data_in0  input  DATA_WIDTH  channel-0 beat (from FIFO output 0).
REQ-006 data_in0_vld  input  1  channel-0 beat valid.
REQ-007 data_in0_rdy  output  1  channel-0 beat accepted when high with data_in0_vld.
REQ-008 data_in1  input  DATA_WIDTH  channel-1 beat (from FIFO output 1).
REQ-009 data_in1_vld  input  1  channel-1 beat valid.
REQ-010 data_in1_rdy  output  1  channel-1 beat accepted when high with data_in1_vld.
REQ-011 data_out  output  DATA_WIDTH  merged beat, head of output buffer.
REQ-012 data_out_src  output  1  source channel of data_out (0 or 1).
REQ-013 data_out_vld  output  1  data_out/data_out_src valid.
REQ-014 data_out_rdy  input  1  downstream accepts head beat when high with data_out_vld.
REQ-015 cnt0  output  CNT_WIDTH  channel-0 accepted-beat count.
REQ-016 cnt1  output  CNT_WIDTH  channel-1 accepted-beat count.

Function
REQ-017 Transfer on any channel SHALL occur exactly on a rising edge where vld and rdy are both high.
REQ-018 Block SHALL hold a 2-entry in-order output buffer of {src, data}; occupancy states EMPTY (0), ONE (1), FULL (2).
REQ-019 Transitions: push only -> occupancy+1; pop only -> occupancy-1; push+pop -> unchanged; neither -> unchanged.
REQ-020 Input rdy SHALL depend only on registered state and the vld inputs, never on data_out_rdy (no combinational path out->in).
REQ-021 Block SHALL be able to accept a beat in a cycle only when occupancy < 2 at the start of that cycle.
REQ-022 Arbitration SHALL be round-robin via a 1-bit last-grant register: both vld -> grant channel != last; single vld -> grant that channel.
REQ-023 data_inN_rdy SHALL be high only for the granted channel and only when acceptance is possible; both rdy never high together.
REQ-024 Last-grant register SHALL update to the granted channel only on an actual transfer.
REQ-025 Accepted beat SHALL appear on data_out with data_out_vld high on the next cycle when the buffer was EMPTY (latency 1 cycle).
REQ-026 data_out_vld SHALL be high iff occupancy != 0; data_out/data_out_src SHALL stay stable while vld high and rdy low.
REQ-027 At FULL, both input rdy SHALL be low even if data_out_rdy is high that cycle; accepting resumes the cycle after a pop.
REQ-028 Sustained throughput SHALL be one beat per cycle when data_out_rdy is held high (occupancy stays at ONE).
REQ-029 Beat order at the output SHALL equal acceptance order; no beat is dropped or duplicated.
REQ-030 cntN SHALL increment by 1 on each channel-N transfer and saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-031 Pop when EMPTY SHALL be impossible; data_out_rdy while data_out_vld low SHALL have no effect.

Reset
REQ-032 While rst is high at a clock edge: occupancy 0, data_out_vld 0, data_out 0, data_out_src 0, cnt0 0, cnt1 0, last-grant 1.
REQ-033 Both input rdy SHALL be low during any cycle rst is high.
REQ-034 Reset mid-operation SHALL discard buffered beats; the first grant after reset with both vld high SHALL go to channel 0.

Verification
REQ-035 Reset release, both vld high, data_in0=0x11, data_in1=0x22, data_out_rdy=1 -> outputs 0x11(src0), 0x22(src1), alternating, one beat/cycle.
REQ-036 Only channel 1 vld with 4 beats 0xA0..0xA3, data_out_rdy=1 -> data_in1_rdy held high; outputs 0xA0..0xA3, src=1, cnt1=4, cnt0=0.
REQ-037 data_out_rdy=0, both vld high -> exactly 2 beats accepted (ch0 then ch1), then both rdy low; data_out frozen at first beat; raise rdy -> drains in order, accepting resumes next cycle.
REQ-038 CNT_WIDTH=4, 20 ch0 beats -> cnt0 stops at 15.
REQ-039 Assert rst for 1 cycle while FULL -> next cycle data_out_vld=0, cnt0=cnt1=0; subsequent both-vld grant goes to channel 0.
REQ-040 Random vld/rdy stall patterns on both channels, 10k beats -> scoreboard per-channel order preserved, cnt totals match beats sent, no grant to a non-vld channel.
